// File: rtl/if_fetch_unit_pkg.sv
// Shared CPU constants and the fetch-stage buffer entry type.
// Imported by the instruction fetch unit and its buffer.
package if_fetch_unit_pkg;

    localparam int XLEN            = 32;
    localparam int INSN_W          = 32;
    localparam int FETCH_BUF_DEPTH = 2;
    localparam int FETCH_CNT_W     = 2;

    localparam logic [XLEN-1:0]   CPU_RESET_VECTOR = 32'h0000_0000;
    localparam logic [INSN_W-1:0] CPU_NOP_INSN     = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INSN_W-1:0] insn;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_buffer.sv
// Two-entry in-order {pc, insn} queue between instruction memory and decode.
// Flush wins over push and pop; push and pop together are legal at any occupancy.
module if_fetch_buffer
    import if_fetch_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [FETCH_CNT_W-1:0] count
);

    localparam logic [FETCH_CNT_W-1:0] CNT_ONE  = FETCH_CNT_W'(1);
    localparam logic [FETCH_CNT_W-1:0] CNT_FULL = FETCH_CNT_W'(FETCH_BUF_DEPTH);

    fetch_entry_t           entry0;
    fetch_entry_t           entry1;
    logic [FETCH_CNT_W-1:0] count_q;
    logic                   do_pop;
    logic                   do_push;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CNT_FULL) || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + FETCH_CNT_W'(do_push) - FETCH_CNT_W'(do_pop);
        end
    end

    // entry0 is always the head; a pop shifts entry1 forward unless the new word lands there directly
    always_ff @(posedge clk) begin
        if (do_pop) begin
            entry0 <= (do_push && (count_q == CNT_ONE)) ? push_entry : entry1;
        end else if (do_push && (count_q == '0)) begin
            entry0 <= push_entry;
        end
        if (do_push && (((count_q == CNT_ONE) && !do_pop) || ((count_q == CNT_FULL) && do_pop))) begin
            entry1 <= push_entry;
        end
    end

    assign head  = entry0;
    assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues word-aligned requests under a two-credit limit,
// buffers in-order responses for decode and discards responses made stale by a redirect.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0]   RESET_PC = CPU_RESET_VECTOR,
    parameter logic [INSN_W-1:0] NOP_INSN = CPU_NOP_INSN
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INSN_W-1:0] imem_rsp_data,
    input  logic              stall_id,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              valid_if,
    output logic [XLEN-1:0]   pc_if,
    output logic [INSN_W-1:0] instruction_if
);

    logic [XLEN-1:0]        fetch_pc;
    logic [1:0]             outstanding;
    logic [1:0]             drop_cnt;
    logic [XLEN-1:0]        tag0;
    logic [XLEN-1:0]        tag1;
    logic [XLEN-1:0]        pc_hold;
    logic [2:0]             credit_used;
    logic                   req_fire;
    logic                   rsp_ok;
    logic                   rsp_keep;
    logic                   pop;
    fetch_entry_t           head;
    fetch_entry_t           push_entry;
    logic [FETCH_CNT_W-1:0] buf_count;

    // Every credit is either a word in flight or a word sitting in the buffer, so the buffer cannot overflow
    assign credit_used    = {1'b0, outstanding} + {1'b0, buf_count};
    assign imem_req_valid = rst_n && !redirect_valid && (credit_used < 3'd2);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_ok   = imem_rsp_valid && (outstanding != 2'd0);
    assign rsp_keep = rsp_ok && (drop_cnt == 2'd0) && !redirect_valid;

    assign valid_if       = rst_n && (buf_count != '0);
    assign pop            = valid_if && !stall_id;
    assign instruction_if = valid_if ? head.insn : NOP_INSN;
    assign pc_if          = valid_if ? head.pc : pc_hold;

    assign push_entry.pc   = tag0;
    assign push_entry.insn = imem_rsp_data;

    if_fetch_buffer u_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (rsp_keep),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .count      (buf_count)
    );

    // drop_cnt counts requests still in flight that belong to the path abandoned by the last redirect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
        end else begin
            outstanding <= outstanding + {1'b0, req_fire} - {1'b0, rsp_ok};
            if (redirect_valid) begin
                fetch_pc <= align_word(redirect_pc);
                drop_cnt <= outstanding - {1'b0, rsp_ok};
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_ok && (drop_cnt != 2'd0)) begin
                    drop_cnt <= drop_cnt - 2'd1;
                end
            end
        end
    end

    // Request pcs in issue order; tag0 belongs to the oldest in-flight request.
    // When a request and a response coincide exactly one was in flight, so the new pc becomes the head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag0 <= '0;
            tag1 <= '0;
        end else if (req_fire && rsp_ok) begin
            tag0 <= fetch_pc;
        end else if (rsp_ok) begin
            tag0 <= tag1;
        end else if (req_fire) begin
            if (outstanding == 2'd0) begin
                tag0 <= fetch_pc;
            end else begin
                tag1 <= fetch_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_hold <= RESET_PC;
        end else if (valid_if) begin
            pc_hold <= head.pc;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a queue-based model of the fetch stage and its memory.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall_id;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        valid_if;
    logic [31:0] pc_if;
    logic [31:0] instruction_if;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_INSN (NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall_id       (stall_id),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .valid_if       (valid_if),
        .pc_if          (pc_if),
        .instruction_if (instruction_if)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } entry_t;

    typedef struct {
        logic        ready;
        logic        stall;
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vector_t;

    // inflight is the memory's view of accepted requests; model_q is what decode should see
    mem_req_t    inflight[$];
    entry_t      model_q[$];
    vector_t     vec[7];
    logic [31:0] model_fetch_pc;
    logic [31:0] model_last_pc;
    int          epoch;
    int          cycle;
    int          checks;
    int          failures;
    int          lat_min;
    int          lat_max;
    int          rsp_pct;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0000_0118) begin
            return 32'h4083_8233;
        end
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_eq(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic apply_stimulus(input logic rst, input logic ready, input logic stall,
                                  input logic redir, input logic [31:0] target);
        @(posedge clk);
        #1;
        cycle++;
        rst_n          = rst;
        imem_req_ready = ready;
        stall_id       = stall;
        redirect_valid = redir;
        redirect_pc    = target;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (rst && (inflight.size() != 0) && (cycle >= inflight[0].due) && ($urandom_range(99) < rsp_pct)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(inflight[0].addr);
        end
    endtask

    // Compare against the model, then advance the model to what the coming clock edge should produce
    task automatic check_output();
        logic     exp_req_valid;
        logic     exp_valid;
        mem_req_t r;
        @(negedge clk);
        exp_req_valid = rst_n && !redirect_valid && ((inflight.size() + model_q.size()) < 2);
        exp_valid     = rst_n && (model_q.size() != 0);
        check_eq("req_valid", imem_req_valid, exp_req_valid);
        if (exp_req_valid) begin
            check_eq("req_addr", imem_req_addr, model_fetch_pc);
        end
        check_eq("valid_if", valid_if, exp_valid);
        if (exp_valid) begin
            check_eq("pc_if", pc_if, model_q[0].pc);
            check_eq("instruction_if", instruction_if, model_q[0].insn);
        end else begin
            check_eq("pc_if_hold", pc_if, model_last_pc);
            check_eq("instruction_nop", instruction_if, NOP);
        end

        if (!rst_n) begin
            inflight.delete();
            model_q.delete();
            epoch++;
            model_fetch_pc = RESET_PC;
            model_last_pc  = RESET_PC;
        end else begin
            if (model_q.size() != 0) begin
                model_last_pc = model_q[0].pc;
                if (!stall_id && !redirect_valid) begin
                    void'(model_q.pop_front());
                end
            end
            if (imem_rsp_valid) begin
                r = inflight.pop_front();
                if ((r.epoch == epoch) && !redirect_valid) begin
                    model_q.push_back('{r.addr, mem_word(r.addr)});
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                inflight.push_back('{imem_req_addr, epoch, cycle + int'($urandom_range(lat_max, lat_min))});
                model_fetch_pc = model_fetch_pc + 32'd4;
            end
            if (redirect_valid) begin
                model_q.delete();
                epoch++;
                model_fetch_pc = {redirect_pc[31:2], 2'b00};
            end
        end
    endtask

    task automatic step(input logic rst, input logic ready, input logic stall,
                        input logic redir, input logic [31:0] target);
        apply_stimulus(rst, ready, stall, redir, target);
        check_output();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic found;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        stall_id       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        model_fetch_pc = RESET_PC;
        model_last_pc  = RESET_PC;
        epoch          = 0;
        cycle          = 0;
        checks         = 0;
        failures       = 0;
        lat_min        = 1;
        lat_max        = 1;
        rsp_pct        = 100;

        // Reset release with ready=1 and single-cycle memory latency
        vec[0] = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vec[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000};
        vec[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vec[3] = '{1'b1, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
        vec[4] = '{1'b1, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 32'h0000_0004};
        vec[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008};
        vec[6] = '{1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C};

        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, vec[i].ready, vec[i].stall, 1'b0, 32'h0);
            check_eq($sformatf("vec%0d_req_valid", i), imem_req_valid, vec[i].exp_req_valid);
            if (vec[i].exp_req_valid) begin
                check_eq($sformatf("vec%0d_req_addr", i), imem_req_addr, vec[i].exp_req_addr);
            end
            check_eq($sformatf("vec%0d_valid_if", i), valid_if, vec[i].exp_valid);
            check_eq($sformatf("vec%0d_pc_if", i), pc_if, vec[i].exp_pc);
            check_eq($sformatf("vec%0d_insn", i), instruction_if,
                     vec[i].exp_valid ? mem_word(vec[i].exp_pc) : NOP);
        end

        // Redirect under stall, then hold the 0x118 word in decode for three stalled cycles
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0118);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            found = valid_if;
        end
        check_eq("stall_head_arrived", found, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            check_eq("stall_hold_valid", valid_if, 1'b1);
            check_eq("stall_hold_pc", pc_if, 32'h0000_0118);
            check_eq("stall_hold_insn", instruction_if, 32'h4083_8233);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("stall_release_pc", pc_if, 32'h0000_0118);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("stall_next_valid", valid_if, 1'b1);
        check_eq("stall_next_pc", pc_if, 32'h0000_011C);

        // Memory not ready for four cycles at 0x20, then exactly one acceptance
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0020);
        check_eq("redirect_no_req", imem_req_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            check_eq("backpressure_valid", imem_req_valid, 1'b1);
            check_eq("backpressure_addr", imem_req_addr, 32'h0000_0020);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("accept_addr", imem_req_addr, 32'h0000_0020);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("after_accept_valid", imem_req_valid, 1'b1);
        check_eq("after_accept_addr", imem_req_addr, 32'h0000_0024);

        // Misaligned redirect target is word-aligned
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0203);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("align_req_valid", imem_req_valid, 1'b1);
        check_eq("align_req_addr", imem_req_addr, 32'h0000_0200);

        // Fetch address wraps from the top of the address space
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("wrap_first_addr", imem_req_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("wrap_valid", imem_req_valid, 1'b1);
        check_eq("wrap_addr", imem_req_addr, 32'h0000_0000);

        // Two requests in flight at 0x100/0x104 when redirecting to 0x200
        lat_min = 3;
        lat_max = 3;
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("inflight_first_addr", imem_req_addr, 32'h0000_0100);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("inflight_second_addr", imem_req_addr, 32'h0000_0104);
        lat_min = 1;
        lat_max = 1;
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0200);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            found = valid_if;
        end
        check_eq("drop_next_arrived", found, 1'b1);
        check_eq("drop_next_pc", pc_if, 32'h0000_0200);

        // Fill under stall, redirect while stalled, then reset mid-stream
        repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("full_valid", valid_if, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0300);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("flush_valid", valid_if, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            check_eq("reset_req_valid", imem_req_valid, 1'b0);
            check_eq("reset_valid_if", valid_if, 1'b0);
            check_eq("reset_insn", instruction_if, NOP);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("restart_req_valid", imem_req_valid, 1'b1);
        check_eq("restart_addr", imem_req_addr, RESET_PC);
        check_eq("restart_valid_if", valid_if, 1'b0);
        check_eq("restart_insn", instruction_if, NOP);
        check_eq("restart_pc_if", pc_if, RESET_PC);

        // Randomized traffic against the model
        lat_max = 4;
        rsp_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] target;
            target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                              : 32'($urandom_range(32'h3FF));
            step($urandom_range(199) != 0, $urandom_range(99) < 70, $urandom_range(99) < 30,
                 $urandom_range(19) == 0, target);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
